// File: rtl/and_or_array_pipe.sv
// Parametrised array of AND-OR / AND-OR-INVERT cells behind a two-stage
// valid/ready pipeline, with a saturating counter of output-word transitions.
module and_or_array_pipe #(
  parameter int unsigned CHANNELS   = 2,
  parameter int unsigned TERMS      = 2,
  parameter int unsigned TERM_WIDTH = 3,
  parameter int unsigned CNT_WIDTH  = 8
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               in_valid,
  output logic                               in_ready,
  input  logic [CHANNELS*TERMS*TERM_WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]                in_mode,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [CHANNELS-1:0]                out_y,
  output logic [CNT_WIDTH-1:0]               trans_cnt,
  input  logic                               clear_cnt
);

  localparam int unsigned NTERMS = CHANNELS * TERMS;

  logic [NTERMS-1:0]    term_and;
  logic [NTERMS-1:0]    s1_terms;
  logic [CHANNELS-1:0]  s1_mode;
  logic                 s1_valid;
  logic [CHANNELS-1:0]  y_next;
  logic [CHANNELS-1:0]  last_y;
  logic                 s1_en;
  logic                 s2_en;
  logic                 in_acc;
  logic                 out_acc;
  logic                 cnt_inc;

  // Product terms: AND across each TERM_WIDTH-bit slice of the input word
  always_comb begin
    term_and = '0;
    for (int unsigned k = 0; k < NTERMS; k++) begin
      term_and[k] = &in_data[k*TERM_WIDTH +: TERM_WIDTH];
    end
  end

  // Per-channel OR of its terms, optionally inverted by the captured mode
  always_comb begin
    y_next = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      y_next[c] = (|s1_terms[c*TERMS +: TERMS]) ^ s1_mode[c];
    end
  end

  always_comb begin
    s2_en    = !out_valid || out_ready;
    s1_en    = !s1_valid || s2_en;
    in_ready = s1_en && !reset;
    in_acc   = in_valid && in_ready;
    out_acc  = out_valid && out_ready;
    cnt_inc  = out_acc && (out_y != last_y) && (trans_cnt != {CNT_WIDTH{1'b1}});
  end

  // Stage 1: term ANDs and mode, loaded only on an accepted word
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_terms <= '0;
      s1_mode  <= '0;
    end else if (s1_en) begin
      s1_valid <= in_acc;
      if (in_acc) begin
        s1_terms <= term_and;
        s1_mode  <= in_mode;
      end
    end
  end

  // Stage 2: cell results; out_y holds while the output is stalled
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_y     <= '0;
    end else if (s2_en) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_y <= y_next;
      end
    end
  end

  // Transition counter; clear wins over a same-cycle increment
  always_ff @(posedge clk) begin
    if (reset) begin
      last_y    <= '0;
      trans_cnt <= '0;
    end else begin
      if (out_acc) begin
        last_y <= out_y;
      end
      if (clear_cnt) begin
        trans_cnt <= '0;
      end else if (cnt_inc) begin
        trans_cnt <= trans_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule
